// File: rtl/logic_op_arbiter_pkg.sv
// Shared constants for the logic-op arbiter: opcode encodings, field widths
// and the result-slot state type.
package logic_op_arbiter_pkg;

   localparam int OP_W    = 3;
   localparam int STATS_W = 16;

   localparam logic [OP_W-1:0] OP_BUF  = 3'd0;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd1;
   localparam logic [OP_W-1:0] OP_AND  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_OR   = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Purely combinational W-bit bitwise logic unit selected by a 3-bit opcode.
module logic_op_unit
   import logic_op_arbiter_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [OP_W-1:0] op,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   output logic [W-1:0]    y
);

   // NOTE: default assignment first so no path through the case can infer a latch.
   always_comb begin
      y = '0;
      case (op)
         OP_BUF:  y = a;
         OP_NOT:  y = ~a;
         OP_AND:  y = a & b;
         OP_NAND: y = ~(a & b);
         OP_OR:   y = a | b;
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: y = a;
      endcase
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit among N requesters, with one
// registered result slot. Optional LOGIC_ARB_STATS_EN adds a saturating rsp_count.
module logic_op_arbiter
   import logic_op_arbiter_pkg::*;
#(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [OP_W*N-1:0] req_op,
   input  logic [W*N-1:0]    req_a,
   input  logic [W*N-1:0]    req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id
`ifdef LOGIC_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0] rsp_count
`endif
);

   localparam logic [IDW:0]   N_EXT    = (IDW+1)'(N);
   localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_next;
   logic [W-1:0]    data_q;
   logic [IDW-1:0]  id_q;

   logic            slot_free, gnt_found, accept;
   logic [IDW-1:0]  gnt_idx;
   logic [IDW:0]    scan_sum;
   logic [IDW-1:0]  scan_idx;
   logic [OP_W-1:0] sel_op;
   logic [W-1:0]    sel_a, sel_b, unit_y;

   assign slot_free = (state_q == ST_EMPTY) || rsp_ready;

   // Scan upward from the pointer, wrapping at N; the first valid requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < N; i++) begin
         scan_sum = {1'b0, ptr_q} + (IDW+1)'(i);
         if (scan_sum >= N_EXT) scan_sum = scan_sum - N_EXT;
         scan_idx = scan_sum[IDW-1:0];
         if (!gnt_found && req_valid[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx;
         end
      end
   end

   assign accept    = slot_free && gnt_found;
   assign req_ready = accept ? (N'(1) << gnt_idx) : '0;
   assign ptr_next  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

   assign sel_op = req_op[gnt_idx*OP_W +: OP_W];
   assign sel_a  = req_a[gnt_idx*W +: W];
   assign sel_b  = req_b[gnt_idx*W +: W];

   logic_op_unit #(.W(W)) u_op_unit (
      .op (sel_op),
      .a  (sel_a),
      .b  (sel_b),
      .y  (unit_y)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q <= unit_y;
            id_q   <= gnt_idx;
            ptr_q  <= ptr_next;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      rsp_valid = (state_q == ST_FULL);
      rsp_data  = data_q;
      rsp_id    = id_q;
   end

`ifdef LOGIC_ARB_STATS_EN
   logic [STATS_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (rsp_valid && rsp_ready && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign rsp_count = count_q;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter (N=4, W=8): grant/latency model plus
// a result scoreboard; rsp_count checks only when LOGIC_ARB_STATS_EN is defined.
module tb_logic_op_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int IDW = 2;

   typedef struct packed {
      logic [W-1:0]   data;
      logic [IDW-1:0] id;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [3*N-1:0]   req_op = '0;
   logic [W*N-1:0]   req_a = '0;
   logic [W*N-1:0]   req_b = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [W-1:0]     rsp_data;
   logic [IDW-1:0]   rsp_id;
`ifdef LOGIC_ARB_STATS_EN
   logic [15:0]      rsp_count;
`endif

   logic_op_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef LOGIC_ARB_STATS_EN
      ,
      .rsp_count (rsp_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [2:0] ops [N];
   logic [7:0] av  [N];
   logic [7:0] bv  [N];

   rsp_t sb [$];
   int   gnt_log [$];
   int   m_ptr = 0;
   logic m_full = 1'b0;
   logic [15:0] m_count = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a;
         3'd1: return ~a;
         3'd2: return a & b;
         3'd3: return ~(a & b);
         3'd4: return a | b;
         3'd5: return ~(a | b);
         3'd6: return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // One clock cycle: drive at negedge, check after settling, advance the model.
   task automatic step(input logic [N-1:0] v, input logic rr, input logic r);
      int g;
      logic found, acc;
      rsp_t e;
      @(negedge clk);
      rst = r;
      req_valid = v;
      rsp_ready = rr;
      for (int i = 0; i < N; i++) begin
         req_op[3*i +: 3] = ops[i];
         req_a[W*i +: W]  = av[i];
         req_b[W*i +: W]  = bv[i];
      end
      #1;
      if (r) begin
         sb.delete();
         m_ptr = 0;
         m_full = 1'b0;
         m_count = '0;
      end else begin
         found = 1'b0;
         g = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && v[(m_ptr + k) % N]) begin
               found = 1'b1;
               g = (m_ptr + k) % N;
            end
         end
         acc = found && (!m_full || rr);
         check("req_ready", req_ready, acc ? (32'd1 << g) : 32'd0);
         check("rsp_valid", rsp_valid, m_full);
`ifdef LOGIC_ARB_STATS_EN
         check("rsp_count", rsp_count, m_count);
`endif
         if (m_full) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", 0, 1);
            end else if (rr) begin
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_id", rsp_id, e.id);
               if (m_count != 16'hFFFF) m_count = m_count + 1'b1;
            end else begin
               check("hold_data", rsp_data, sb[0].data);
               check("hold_id", rsp_id, sb[0].id);
            end
         end
         if (acc) begin
            e.data = ref_op(ops[g], av[g], bv[g]);
            e.id = IDW'(g);
            sb.push_back(e);
            gnt_log.push_back(g);
            m_ptr = (g + 1) % N;
         end
         m_full = acc || (m_full && !rr);
      end
   endtask

   logic [7:0] op_tbl [8];
   int exp_seq [6];

   initial begin
      op_tbl = '{8'hF0, 8'h0F, 8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33};
      exp_seq = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < N; i++) begin
         ops[i] = 3'(i);
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
      end

      // Reset then idle.
      step('0, 1'b1, 1'b1);
      step('0, 1'b1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step('0, 1'b1, 1'b0);
         check("idle_data", rsp_data, 8'h00);
      end

      // Opcode sweep on requester 2.
      for (int k = 0; k < 8; k++) begin
         ops[2] = 3'(k);
         av[2] = 8'hF0;
         bv[2] = 8'h3C;
         step(4'b0100, 1'b1, 1'b0);
         check("grant_r2", req_ready, 4'b0100);
         step(4'b0000, 1'b1, 1'b0);
         check("op_tbl", rsp_data, op_tbl[k]);
         check("op_id", rsp_id, 2);
      end

      // Fairness from a fresh pointer.
      step('0, 1'b1, 1'b1);
      gnt_log.delete();
      for (int c = 0; c < 6; c++) step(4'b1111, 1'b1, 1'b0);
      check("fair_len", gnt_log.size(), 6);
      for (int c = 0; c < 6 && c < gnt_log.size(); c++) check("fair_seq", gnt_log[c], exp_seq[c]);
      step('0, 1'b1, 1'b0);

      // Backpressure, then same-cycle drain and accept.
      step(4'b1111, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step(4'b1111, 1'b0, 1'b0);
         check("bp_ready", req_ready, 4'b0000);
      end
      step(4'b1111, 1'b1, 1'b0);
      check("no_bubble", req_ready != 0, 1);

      // Reset while holding a stalled result.
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b1);
      step(4'b1111, 1'b1, 1'b0);
      check("post_rst_valid", rsp_valid, 1'b0);
      check("post_rst_grant", req_ready, 4'b0001);

      // Random traffic.
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < N; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
         end
         step(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      end

`ifdef LOGIC_ARB_STATS_EN
      step('0, 1'b1, 1'b1);
      for (int c = 0; c < 10; c++) step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      check("count_10", rsp_count, 16'd10);
      @(negedge clk);
      force dut.count_q = 16'hFFFE;
      @(negedge clk);
      release dut.count_q;
      m_count = 16'hFFFE;
      for (int c = 0; c < 3; c++) step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      check("count_sat", rsp_count, 16'hFFFF);
`endif

      // Drain whatever is left.
      for (int c = 0; c < 4; c++) step('0, 1'b1, 1'b0);
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
